// File: rtl/quadram_arbiter.sv
// quadram_arbiter: round-robin front end for the single-port 2048x32 quad RAM.
// Grants one requester per cycle, routes its request onto the RAM pins, returns
// read data one cycle later, and sequences a drained end-of-run RAM dump.

// Per-requester response tracker: remembers that this lane's read was accepted
// so the registered RAM output can be steered back to it next cycle.
module quadram_arbiter_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic rd,
  output logic pend
);
  // One-cycle read-response flag; reset discards any in-flight response.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= 1'b0;
    else        pend <= acc & rd;
endmodule

module quadram_arbiter #(
  parameter int N_REQ   = 3,
  parameter int A_WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [4*N_REQ-1:0]         req_we,
  input  logic [A_WIDTH*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]        req_wdata,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       ram_en,
  output logic [3:0]                 ram_we,
  output logic [A_WIDTH-1:0]         ram_addr,
  output logic [31:0]                ram_din,
  input  logic [31:0]                ram_dout,
  output logic                       ram_wr,
  input  logic                       dump_req,
  output logic                       dump_ack
);
  localparam int              PW   = $clog2(N_REQ);
  localparam logic [PW:0]     NR   = (PW+1)'(N_REQ);
  localparam logic [PW-1:0]   LAST = PW'(N_REQ-1);

  localparam logic [1:0] S_ARB   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0]         we;
    logic [A_WIDTH-1:0] addr;
    logic [31:0]        wdata;
  } req_t;

  req_t [N_REQ-1:0] rq;
  logic [1:0]       state, state_nx;
  logic [PW-1:0]    ptr, gidx;
  logic [PW:0]      scan;
  logic             found, grant_en, acc;
  logic [N_REQ-1:0] gnt, pend;

  // Unpack the flat request buses and attach a response tracker per lane.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign rq[g].we    = req_we[4*g +: 4];
    assign rq[g].addr  = req_addr[A_WIDTH*g +: A_WIDTH];
    assign rq[g].wdata = req_wdata[32*g +: 32];

    quadram_arbiter_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .acc  (gnt[g]),
      .rd   (rq[g].we == 4'b0000),
      .pend (pend[g])
    );
  end

  // Grants are only possible in ARB without a pending dump; gating with rst_n
  // keeps ready and the RAM pins low for the whole reset window.
  assign grant_en = rst_n & (state == S_ARB) & ~dump_req;

  // Scan from the pointer upward modulo N_REQ for the first valid requester.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= NR) scan = scan - NR;
      if (!found && req_valid[scan[PW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[PW-1:0];
      end
    end
    if (grant_en && found) gnt[gidx] = 1'b1;
  end

  assign acc       = grant_en & found;
  assign req_ready = gnt;

  // RAM request pins follow the winner and are all-zero when nothing is accepted.
  always_comb begin
    ram_en   = acc;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (acc) begin
      ram_we   = rq[gidx].we;
      ram_addr = rq[gidx].addr;
      ram_din  = rq[gidx].wdata;
    end
  end

  // Read data is shared; only the lane whose read landed sees a valid bit.
  assign rsp_valid = pend;
  assign rsp_rdata = (|pend) ? ram_dout : '0;

  // Priority pointer: lock pins priority on the winner, otherwise rotate past it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   ptr <= '0;
    else if (acc) ptr <= req_lock[gidx] ? gidx : ((gidx == LAST) ? '0 : gidx + 1'b1);

  // Dump sequencer next state; once started, DRAIN/DUMP always run to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_ARB:   if (dump_req) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DUMP;
      S_DUMP:  state_nx = S_DONE;
      S_DONE:  if (!dump_req) state_nx = S_ARB;
      default: state_nx = S_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_ARB;
    else        state <= state_nx;

  assign ram_wr   = (state == S_DUMP);
  assign dump_ack = (state == S_DONE);
endmodule

// File: tb/tb_quadram_arbiter.sv
// Bench for quadram_arbiter: behavioural RAM, directed grant checks, and a
// scoreboard of expected read responses keyed by the cycle they must appear.
module tb_quadram_arbiter;
  localparam int N  = 3;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_ready, req_lock, rsp_valid;
  logic [N-1:0][3:0]     t_we;
  logic [N-1:0][AW-1:0]  t_addr;
  logic [N-1:0][31:0]    t_wd;
  logic [4*N-1:0]        req_we;
  logic [AW*N-1:0]       req_addr;
  logic [32*N-1:0]       req_wdata;
  logic [31:0]           rsp_rdata, ram_din, ram_dout;
  logic                  ram_en, ram_wr, dump_req, dump_ack;
  logic [3:0]            ram_we;
  logic [AW-1:0]         ram_addr;

  assign req_we    = t_we;
  assign req_addr  = t_addr;
  assign req_wdata = t_wd;

  quadram_arbiter #(.N_REQ(N), .A_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_wr(ram_wr),
    .dump_req(dump_req), .dump_ack(dump_ack)
  );

  // Behavioural RAM: byte-enabled write, registered read, plus a preload port.
  logic [31:0]   mem [0:2047];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [N-1:0] mask;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Response monitor: each cycle either the due response or a silent bus.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
        chk("rsp_missed_cyc", cyc_n, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc_n) begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, e.mask);
        chk("rsp_rdata", rsp_rdata, e.data);
      end else begin
        chk("rsp_idle_v", rsp_valid, '0);
        chk("rsp_idle_d", rsp_rdata, '0);
      end
    end
  end

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] we,
                         input logic [AW-1:0] a, input logic [31:0] d, input logic lk);
    req_valid[i] = v; t_we[i] = we; t_addr[i] = a; t_wd[i] = d; req_lock[i] = lk;
  endtask

  // Check the grant and RAM pins at mid-cycle; queue the read response if asked.
  task automatic expect_grant(input string tag, input logic [N-1:0] m,
                              input logic [AW-1:0] ea, input logic [3:0] ewe,
                              input logic [31:0] ed, input logic [31:0] rd, input bit push);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, m);
    chk({tag, "_en"},    ram_en, |m);
    chk({tag, "_we"},    ram_we, ewe);
    chk({tag, "_addr"},  ram_addr, ea);
    chk({tag, "_din"},   ram_din, ed);
    if (push) sb.push_back('{cyc_n + 1, m, rd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc_n);
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_lock = '0; t_we = '0; t_addr = '0; t_wd = '0;
    dump_req = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Reset: a valid requester must still see no grant, all outputs low.
    set_req(0, 1'b1, 4'h0, 11'h010, 32'h0, 1'b0);
    preload(11'h010, 32'hDEADBEEF);
    preload(11'h020, 32'hAABBCCDD);
    for (int i = 0; i < N; i++) preload(AW'(11'h100 + i), pat(AW'(11'h100 + i)));
    @(negedge clk);
    chk("rst_ready", req_ready, '0);
    chk("rst_en", ram_en, 1'b0);
    chk("rst_we", ram_we, '0);
    chk("rst_addr", ram_addr, '0);
    chk("rst_din", ram_din, '0);
    chk("rst_rsp_v", rsp_valid, '0);
    chk("rst_rsp_d", rsp_rdata, '0);
    chk("rst_wr", ram_wr, 1'b0);
    chk("rst_ack", dump_ack, 1'b0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;

    // Round-robin: everyone valid, no lock -> 0,1,2,0,1,2.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'h0, AW'(11'h100 + i), 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expect_grant("rr", N'(1 << (k % N)), AW'(11'h100 + k % N), 4'h0, 32'h0,
                   pat(AW'(11'h100 + k % N)), 1'b1);
      tick();
    end
    req_valid = '0;

    // Single read from requester 1, then an idle cycle with stale request data.
    set_req(1, 1'b1, 4'h0, 11'h010, 32'h0, 1'b0);
    expect_grant("single", 3'b010, 11'h010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    tick();
    req_valid[1] = 1'b0;
    expect_grant("idle", 3'b000, '0, 4'h0, 32'h0, 32'h0, 1'b0);
    tick();

    // Lock: pointer sits at 2; requester 2 holds priority for four accesses.
    set_req(0, 1'b1, 4'h0, 11'h100, 32'h0, 1'b0);
    set_req(1, 1'b1, 4'h0, 11'h101, 32'h0, 1'b0);
    set_req(2, 1'b1, 4'hF, 11'h030, 32'hA0A0_0030, 1'b1);
    expect_grant("lock1", 3'b100, 11'h030, 4'hF, 32'hA0A0_0030, 32'h0, 1'b0);
    tick();
    set_req(2, 1'b1, 4'hF, 11'h031, 32'hA0A0_0031, 1'b1);
    expect_grant("lock2", 3'b100, 11'h031, 4'hF, 32'hA0A0_0031, 32'h0, 1'b0);
    tick();
    set_req(2, 1'b1, 4'h0, 11'h030, 32'h0, 1'b1);
    expect_grant("lock3", 3'b100, 11'h030, 4'h0, 32'h0, 32'hA0A0_0030, 1'b1);
    tick();
    set_req(2, 1'b1, 4'h0, 11'h031, 32'h0, 1'b0);
    expect_grant("lock4", 3'b100, 11'h031, 4'h0, 32'h0, 32'hA0A0_0031, 1'b1);
    tick();
    req_valid[2] = 1'b0;
    expect_grant("unlock", 3'b001, 11'h100, 4'h0, 32'h0, pat(11'h100), 1'b1);
    tick();
    req_valid = '0;

    // Byte write then read-back: bytes 0 and 2 replaced.
    set_req(0, 1'b1, 4'b0101, 11'h020, 32'h11223344, 1'b0);
    expect_grant("bw_wr", 3'b001, 11'h020, 4'b0101, 32'h11223344, 32'h0, 1'b0);
    tick();
    set_req(0, 1'b1, 4'h0, 11'h020, 32'h0, 1'b0);
    expect_grant("bw_rd", 3'b001, 11'h020, 4'h0, 32'h0, 32'hAA22CC44, 1'b1);
    tick();
    req_valid = '0;

    // Dump: write 0x7FF, then raise dump_req with requester 1 waiting.
    set_req(0, 1'b1, 4'hF, 11'h7FF, 32'h5A5A5A5A, 1'b0);
    expect_grant("dmp_wr", 3'b001, 11'h7FF, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 4'h0, 11'h7FF, 32'h0, 1'b0);
    dump_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) dump_req = 1'b0;
      expect_grant("dmp_blk", 3'b000, '0, 4'h0, 32'h0, 32'h0, 1'b0);
      chk("dmp_wr_strobe", ram_wr, k == 2);
      chk("dmp_ack", dump_ack, k >= 3);
      if (k == 2) chk("dmp_committed", mem[11'h7FF], 32'h5A5A5A5A);
      tick();
    end
    expect_grant("dmp_resume", 3'b010, 11'h7FF, 4'h0, 32'h0, 32'h5A5A5A5A, 1'b1);
    chk("dmp_ack_clr", dump_ack, 1'b0);
    tick();
    req_valid = '0;

    // Reset right after a read accept: the in-flight response must vanish.
    set_req(2, 1'b1, 4'h0, 11'h010, 32'h0, 1'b0);
    set_req(0, 1'b1, 4'h0, 11'h100, 32'h0, 1'b0);
    expect_grant("pre_rst", 3'b100, 11'h010, 4'h0, 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, '0);
    chk("mid_rst_en", ram_en, 1'b0);
    chk("mid_rst_addr", ram_addr, '0);
    chk("mid_rst_rsp_v", rsp_valid, '0);
    chk("mid_rst_rsp_d", rsp_rdata, '0);
    #1;
    rst_n = 1'b1;
    expect_grant("post_rst", 3'b001, 11'h100, 4'h0, 32'h0, pat(11'h100), 1'b1);
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
